// File: rtl/parity_frame_ctrl_pkg.sv
// Shared types and constants for the
// receive-side parity frame controller.
package parity_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;
  localparam int   ERR_CNT_W   = 8;

endpackage

// File: rtl/parity_frame_ctrl_if.sv
// Output word stream: registered word plus
// error flags under a valid/ready handshake.
interface parity_frame_ctrl_if #(
  parameter int DATA_W = 8
);

  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              dout_ready;
  logic              parityerror;
  logic              frameerror;

  modport master (
    output dout,
    output dout_valid,
    output parityerror,
    output frameerror,
    input  dout_ready
  );

  modport slave (
    input  dout,
    input  dout_valid,
    input  parityerror,
    input  frameerror,
    output dout_ready
  );

endinterface

// File: rtl/parity_frame_ctrl_accum.sv
// Registered running XOR with clear/enable and
// a compare against the configured parity sense.
module parity_accum #(
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  input  logic d,
  output logic acc,
  output logic err
);

  always_ff @(posedge clk) begin
    if (!reset_n)
      acc <= 1'b0;
    else if (clr)
      acc <= 1'b0;
    else if (en)
      acc <= acc ^ d;
  end

  assign err = (acc != PARITY_ODD);

endmodule

// File: rtl/parity_frame_ctrl.sv
// Serial frame sequencer: start, data LSB first,
// parity, stop; one-deep output register.
module parity_frame_ctrl
  import parity_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 load,
  input  logic                 rxin,
  parity_frame_ctrl_if.master  out,
  output logic                 overrun,
  output logic                 busy,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int CW = $clog2(DATA_W + 1);

  state_t            state, nxt;
  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] sh;
  logic              clr, en, done;
  logic              acc, perr;

  parity_accum #(
    .PARITY_ODD (PARITY_ODD)
  ) u_acc (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (clr),
    .en      (en),
    .d       (rxin),
    .acc     (acc),
    .err     (perr)
  );

  always_ff @(posedge clk) begin
    if (!reset_n)
      state <= IDLE;
    else
      state <= nxt;
  end

  always_comb begin
    nxt  = state;
    clr  = 1'b0;
    en   = 1'b0;
    done = 1'b0;
    unique case (1'b1)
      (state == IDLE): begin
        if (load && !rxin) begin
          nxt = DATA;
          clr = 1'b1;
        end
      end
      (state == DATA): begin
        if (load) begin
          en = 1'b1;
          if (cnt == CW'(DATA_W - 1))
            nxt = PARITY;
        end
      end
      (state == PARITY): begin
        if (load) begin
          en  = 1'b1;
          nxt = STOP;
        end
      end
      default: begin
        if (load) begin
          done = 1'b1;
          nxt  = IDLE;
        end
      end
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt <= '0;
      sh  <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (state == DATA && load) begin
      cnt <= cnt + 1'b1;
      sh  <= {rxin, sh[DATA_W-1:1]};
    end
  end

  // A completing frame may replace a word that drains this cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out.dout        <= '0;
      out.dout_valid  <= 1'b0;
      out.parityerror <= 1'b0;
      out.frameerror  <= 1'b0;
      overrun         <= 1'b0;
    end else if (done) begin
      if (!out.dout_valid || out.dout_ready) begin
        out.dout        <= sh;
        out.dout_valid  <= 1'b1;
        out.parityerror <= perr;
        out.frameerror  <= !rxin;
      end else begin
        overrun <= 1'b1;
      end
    end else if (out.dout_valid && out.dout_ready) begin
      out.dout_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n)
      err_count <= '0;
    else if (done && (perr || !rxin) && err_count != '1)
      err_count <= err_count + 1'b1;
  end

endmodule

// File: tb/tb_parity_frame_ctrl.sv
// Directed plus randomized frames against even and
// odd parity instances with a frame-level model.
module tb_parity_frame_ctrl;

  logic clk = 1'b0;
  logic reset_n;
  logic load;
  logic rxin;
  logic rdy;

  always #5 clk = ~clk;

  parity_frame_ctrl_if #(.DATA_W(8)) ifc0 ();
  parity_frame_ctrl_if #(.DATA_W(8)) ifc1 ();

  assign ifc0.dout_ready = rdy;
  assign ifc1.dout_ready = rdy;

  wire       o_ov [2];
  wire       o_bsy[2];
  wire [7:0] o_ec [2];

  parity_frame_ctrl #(.DATA_W(8), .PARITY_ODD(1'b0)) dut0 (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (load),
    .rxin      (rxin),
    .out       (ifc0),
    .overrun   (o_ov[0]),
    .busy      (o_bsy[0]),
    .err_count (o_ec[0])
  );

  parity_frame_ctrl #(.DATA_W(8), .PARITY_ODD(1'b1)) dut1 (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (load),
    .rxin      (rxin),
    .out       (ifc1),
    .overrun   (o_ov[1]),
    .busy      (o_bsy[1]),
    .err_count (o_ec[1])
  );

  wire       o_v [2];
  wire [7:0] o_d [2];
  wire       o_pe[2];
  wire       o_fe[2];

  assign o_v[0]  = ifc0.dout_valid;
  assign o_v[1]  = ifc1.dout_valid;
  assign o_d[0]  = ifc0.dout;
  assign o_d[1]  = ifc1.dout;
  assign o_pe[0] = ifc0.parityerror;
  assign o_pe[1] = ifc1.parityerror;
  assign o_fe[0] = ifc0.frameerror;
  assign o_fe[1] = ifc1.frameerror;

  int tests = 0;
  int fails = 0;

  logic       ev[2];
  logic [7:0] ed[2];
  logic       ep[2];
  logic       ef[2];
  logic       eo[2];
  int         ec[2];
  logic       eb;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s.valid%0d", tag, k), 32'(o_v[k]), 32'(ev[k]));
      chk($sformatf("%s.dout%0d", tag, k), 32'(o_d[k]), 32'(ed[k]));
      chk($sformatf("%s.perr%0d", tag, k), 32'(o_pe[k]), 32'(ep[k]));
      chk($sformatf("%s.ferr%0d", tag, k), 32'(o_fe[k]), 32'(ef[k]));
      chk($sformatf("%s.ovr%0d", tag, k), 32'(o_ov[k]), 32'(eo[k]));
      chk($sformatf("%s.cnt%0d", tag, k), 32'(o_ec[k]), 32'(ec[k]));
      chk($sformatf("%s.busy%0d", tag, k), 32'(o_bsy[k]), 32'(eb));
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      ev[k] = 1'b0;
      ed[k] = 8'h00;
      ep[k] = 1'b0;
      ef[k] = 1'b0;
      eo[k] = 1'b0;
      ec[k] = 0;
    end
    eb = 1'b0;
  endtask

  // One clock; fin marks the stop-bit strobe of frame d/pbit.
  task automatic step(input logic ld, input logic b, input logic fin,
                      input logic [7:0] d, input logic pbit);
    logic take[2];
    logic pe;
    for (int k = 0; k < 2; k++)
      take[k] = ev[k] && rdy;
    load = ld;
    rxin = b;
    @(posedge clk);
    #1;
    load = 1'b0;
    for (int k = 0; k < 2; k++) begin
      if (fin) begin
        pe = (((^d) ^ pbit) != k[0]);
        if (!ev[k] || take[k]) begin
          ev[k] = 1'b1;
          ed[k] = d;
          ep[k] = pe;
          ef[k] = !b;
        end else begin
          eo[k] = 1'b1;
        end
        if ((pe || !b) && ec[k] < 255)
          ec[k]++;
      end else if (take[k]) begin
        ev[k] = 1'b0;
      end
    end
  endtask

  task automatic do_reset(input int n);
    reset_n = 1'b0;
    repeat (n) step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    reset_n = 1'b1;
    model_clear();
  endtask

  task automatic frame(input logic [7:0] d, input logic pbit,
                       input logic stop, input int maxgap);
    logic [10:0] bits;
    bits = {stop, pbit, d, 1'b0};
    for (int i = 0; i < 11; i++) begin
      repeat ($urandom_range(maxgap, 0))
        step(1'b0, 1'($urandom), 1'b0, d, pbit);
      step(1'b1, bits[i], (i == 10), d, pbit);
      if (i == 0) eb = 1'b1;
    end
    eb = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [7:0] d;
    logic [7:0] pat;
    load    = 1'b0;
    rxin    = 1'b0;
    rdy     = 1'b0;
    reset_n = 1'b0;
    model_clear();
    do_reset(2);
    check_all("reset");

    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    pat = 8'h0B;
    for (int i = 0; i < 4; i++)
      step(1'b1, pat[i], 1'b0, 8'h00, 1'b0);
    eb = 1'b1;
    check_all("partial");
    do_reset(1);
    check_all("midreset");

    rdy = 1'b1;
    frame(8'h09, 1'b0, 1'b1, 0);
    check_all("clean");
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    check_all("clean_drain");

    frame(8'h09, 1'b1, 1'b1, 0);
    check_all("parity");

    frame(8'hA5, 1'b0, 1'b0, 0);
    check_all("framing");

    rdy = 1'b0;
    frame(8'h11, 1'b0, 1'b1, 0);
    frame(8'h22, 1'b0, 1'b1, 0);
    check_all("overrun");
    rdy = 1'b1;
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    check_all("ovr_drain");

    do_reset(1);
    for (int n = 0; n < 40; n++) begin
      d   = 8'($urandom);
      rdy = 1'($urandom_range(3, 0) != 0);
      repeat ($urandom_range(2, 0))
        step(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
      frame(d, 1'($urandom), 1'($urandom_range(4, 0) != 0), 3);
      check_all($sformatf("rand%0d", n));
    end

    rdy = 1'b1;
    for (int n = 0; n < 260; n++)
      frame(8'($urandom), 1'($urandom), 1'b0, 0);
    check_all("saturate");
    chk("sat_cnt0", 32'(o_ec[0]), 32'd255);
    chk("sat_cnt1", 32'(o_ec[1]), 32'd255);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/parity_frame_ctrl.md
# parity_frame_ctrl

Sequencing controller for the receive-side parity check path. Samples a serial frame on `rxin` one bit per `load` strobe: start bit, DATA_W data bits LSB first, one parity bit, one stop bit. It accumulates parity, checks it and the stop bit, and presents the assembled word with error flags through a one-deep valid/ready output register. It sits between the bit-sampling front end and the consumer of received bytes, and keeps a saturating error count for status reads.

## Interface
- `DATA_W`, 8, data bits per frame (2..16)
- `PARITY_ODD`, 0, 0 = even parity (XOR of data and parity bit must be 0); 1 = odd (XOR must be 1)
- `clk`  input  1  sole clock; all logic on rising edge
- `reset_n`  input  1  synchronous, active-low reset
- `load`  input  1  bit strobe; `rxin` is sampled only in cycles where `load`=1
- `rxin`  input  1  serial data bit
- `dout`  output  DATA_W  received word, stable while `dout_valid`=1
- `dout_valid`  output  1  word available
- `dout_ready`  input  1  consumer accepts; transfer happens when `dout_valid`&`dout_ready`
- `parityerror`  output  1  parity mismatch for the word in `dout`; qualified by `dout_valid`
- `frameerror`  output  1  stop bit was 0 for the word in `dout`; qualified by `dout_valid`
- `overrun`  output  1  sticky; a frame completed while the output was still full; cleared by reset only
- `busy`  output  1  FSM not in IDLE
- `err_count`  output  8  count of frames with parity or frame error, saturates at 255

## Operation
- States: IDLE, DATA, PARITY, STOP.
- IDLE: `load`&`rxin`=0 (start bit) moves to DATA and clears the bit counter and parity accumulator. `load`&`rxin`=1 is ignored.
- DATA: each `load` shifts `rxin` into the shift register at the MSB and right-shifts, so the first bit ends in bit 0. It also XORs `rxin` into the accumulator. After the DATA_W-th bit, moves to PARITY.
- PARITY: on `load`, XOR `rxin` into the accumulator, then move to STOP.
- STOP: on `load`, complete the frame and return to IDLE:
  - parity error = accumulator ≠ PARITY_ODD
  - frame error = (`rxin`=0)
  - If the output is empty, or is being drained this cycle (`dout_valid`&`dout_ready`), load `dout`/`parityerror`/`frameerror` and set `dout_valid`.
  - Otherwise drop the frame, set `overrun`, and leave the output untouched.
- `err_count` increments on every completed frame with either error, including dropped frames. It holds at 255.
- Cycles without `load` hold all state. `load` is ignored during no state other than as described above.
- `dout_valid` clears on handshake unless a new frame loads in the same cycle, in which case it stays 1 with the new data.
- Reset (any state, mid-frame included): FSM to IDLE, partial frame discarded. All outputs 0: `dout`=0, `dout_valid`=0, `parityerror`=0, `frameerror`=0, `overrun`=0, `busy`=0, `err_count`=0.

## Timing
- All outputs are registered. No combinational path from inputs to outputs.
- Latency: `dout_valid` rises in the cycle after the clock edge that samples the stop-bit `load`.
- Minimum frame is DATA_W+3 `load` cycles. Back-to-back `load` on every clock is supported.
- `busy` is 1 from the cycle after the start-bit edge until the cycle after the stop-bit edge.
- `dout_ready` may be held high permanently. The output then accepts every frame and overrun never occurs.
- `load`=1 with `reset_n`=0: reset wins.

## Structure
- Shared package `parity_pkg`:
  - FSM state enum (IDLE, DATA, PARITY, STOP)
  - constants PARITY_EVEN=0 and PARITY_ODD=1
  - ERR_CNT_W=8
- One sub-module, `parity_accum`: a registered running XOR with synchronous clear and enable, and `PARITY_ODD` compare output. The top holds the FSM, bit counter, shift register, output register and error counter.
- Bit counter width: $clog2(DATA_W+1).

## Test plan
- Reset mid-frame: 4 data bits shifted, `reset_n`=0 for one cycle → all outputs 0. A following clean frame for 8'h09 is received correctly.
- Clean frame, even parity: start 0, data 8'h09 LSB first, parity 0, stop 1, `dout_ready`=1 → `dout`=8'h09, `dout_valid` for 1 cycle, both error flags 0, `err_count`=0.
- Parity error: same frame with parity bit 1 → `parityerror`=1, `err_count`=1. With PARITY_ODD=1 and parity 1 → no error.
- Framing error: stop bit 0 with data 8'hA5 and correct parity → `frameerror`=1, `dout`=8'hA5, `err_count` increments.
- Backpressure/overrun: `dout_ready`=0, two clean frames 8'h11 then 8'h22 → `dout` stays 8'h11 and `overrun`=1. Raise `dout_ready` → one transfer of 8'h11, then `dout_valid`=0.
- Gapped strobes and saturation: random idle cycles between `load` pulses give results identical to back-to-back. 260 erroneous frames → `err_count`=255.
